// File: rtl/mem_lsu.sv
// Load/store unit in front of the unified 64-bit memory: one request in flight, alignment
// checking, and big-endian load extraction with optional sign extension.
module mem_lsu #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_dword,
  output logic [1:0]   mem_memwrite,
  output logic [N-1:0] mem_dataadr,
  output logic [N-1:0] mem_writedata,
  input  logic [N-1:0] mem_readdata
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q;
  logic         write_q, signed_q, err_q, rerr_q;
  logic [1:0]   size_q;
  logic [N-1:0] addr_q, wdata_q, rdata_q;

  logic         accept, err_d, exec;
  logic [31:0]  w;
  logic [7:0]   b;
  logic [N-1:0] ld_data, rdata_d;

  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & resp_ready);
  assign accept    = req_valid & req_ready;
  assign exec      = (state_q == EXEC);

  assign err_d = (req_size == 2'd3) |
                 ((req_size == 2'd1) & (|req_addr[1:0])) |
                 ((req_size == 2'd2) & (|req_addr[2:0]));

  // Memory returns the addressed 32-bit word in the low half for non-dword reads.
  assign w = mem_readdata[31:0];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    ld_data = {{(N-8){signed_q & b[7]}}, b};
      2'd1:    ld_data = {{(N-32){signed_q & w[31]}}, w};
      default: ld_data = mem_readdata;
    endcase
  end

  assign rdata_d = (write_q | err_q) ? '0 : ld_data;

  always_comb begin
    mem_memwrite = 2'd0;
    if (exec & write_q & ~err_q) begin
      case (size_q)
        2'd0:    mem_memwrite = 2'd2;
        2'd1:    mem_memwrite = 2'd1;
        2'd2:    mem_memwrite = 2'd3;
        default: mem_memwrite = 2'd0;
      endcase
    end
  end

  assign mem_dword     = exec & ~write_q & ~err_q & (size_q == 2'd2);
  assign mem_dataadr   = addr_q;
  assign mem_writedata = wdata_q;
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = rerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= err_d;
      end
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          rdata_q <= rdata_d;
          rerr_q  <= err_q;
          state_q <= RESP;
        end
        RESP: if (resp_ready) state_q <= req_valid ? EXEC : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small big-endian memory model behind it.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_dword;
  logic [63:0] resp_rdata, mem_dataadr, mem_writedata, mem_readdata;
  logic [1:0]  mem_memwrite;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem_m [0:15];

  always #5 clk = ~clk;

  mem_lsu #(.N(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_dword(mem_dword),
    .mem_memwrite(mem_memwrite), .mem_dataadr(mem_dataadr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Dword-organised memory; non-dword reads return the addressed word in the low half.
  always_comb begin
    if (mem_dword) mem_readdata = mem_m[mem_dataadr[6:3]];
    else if (mem_dataadr[2]) mem_readdata = {32'h0, mem_m[mem_dataadr[6:3]][31:0]};
    else mem_readdata = {32'h0, mem_m[mem_dataadr[6:3]][63:32]};
  end

  always @(posedge clk) begin
    case (mem_memwrite)
      2'd3: mem_m[mem_dataadr[6:3]] <= mem_writedata;
      2'd1: if (mem_dataadr[2]) mem_m[mem_dataadr[6:3]][31:0] <= mem_writedata[31:0];
            else mem_m[mem_dataadr[6:3]][63:32] <= mem_writedata[31:0];
      2'd2: mem_m[mem_dataadr[6:3]][63-8*mem_dataadr[2:0] -: 8] <= mem_writedata[7:0];
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [1:0] exp_mw, input logic exp_dw,
                      input logic [63:0] exp_rd, input logic exp_err, input string tag);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    chk({tag, ".exec_memwrite"}, 64'(mem_memwrite), 64'(exp_mw));
    chk({tag, ".exec_dword"}, 64'(mem_dword), 64'(exp_dw));
    chk({tag, ".exec_dataadr"}, mem_dataadr, a);
    chk({tag, ".exec_resp_valid"}, 64'(resp_valid), 64'd0);
    if (exp_mw != 2'd0) chk({tag, ".exec_writedata"}, mem_writedata, wd);
    tick;
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, ".resp_err"}, 64'(resp_err), 64'(exp_err));
    chk({tag, ".resp_memwrite"}, 64'(mem_memwrite), 64'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, ".idle_resp_valid"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 64'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.memwrite", 64'(mem_memwrite), 64'd0);
    chk("rst.dword", 64'(mem_dword), 64'd0);
    chk("rst.dataadr", mem_dataadr, 64'd0);
    chk("rst.writedata", mem_writedata, 64'd0);
    tick;

    xact(1, 2, 0, 64'h10, 64'h1122334455667788, 2'd3, 0, 64'h0, 0, "st_d10");
    xact(0, 2, 0, 64'h10, 64'h0, 2'd0, 1, 64'h1122334455667788, 0, "ld_d10");
    xact(0, 0, 0, 64'h14, 64'h0, 2'd0, 0, 64'h55, 0, "lbu_14");
    xact(0, 0, 1, 64'h17, 64'h0, 2'd0, 0, 64'hFFFFFFFFFFFFFF88, 0, "lb_17");
    xact(0, 0, 1, 64'h11, 64'h0, 2'd0, 0, 64'h22, 0, "lb_11");
    xact(1, 1, 0, 64'h1C, 64'h80000001, 2'd1, 0, 64'h0, 0, "st_w1c");
    xact(0, 1, 1, 64'h1C, 64'h0, 2'd0, 0, 64'hFFFFFFFF80000001, 0, "lw_1c");
    xact(0, 1, 0, 64'h1C, 64'h0, 2'd0, 0, 64'h0000000080000001, 0, "lwu_1c");
    xact(1, 0, 0, 64'h28, 64'hAB, 2'd2, 0, 64'h0, 0, "st_b28");
    xact(0, 0, 0, 64'h28, 64'h0, 2'd0, 0, 64'hAB, 0, "lbu_28");

    xact(1, 1, 0, 64'h1A, 64'hDEADBEEF, 2'd0, 0, 64'h0, 1, "err_sw1a");
    xact(0, 2, 0, 64'h14, 64'h0, 2'd0, 0, 64'h0, 1, "err_ld14");
    xact(0, 3, 0, 64'h10, 64'h0, 2'd0, 0, 64'h0, 1, "err_sz3ld");
    xact(1, 3, 0, 64'h10, 64'hFFFFFFFFFFFFFFFF, 2'd0, 0, 64'h0, 1, "err_sz3st");
    xact(0, 2, 0, 64'h18, 64'h0, 2'd0, 1, 64'h0000000080000001, 0, "ld_d18");
    xact(0, 2, 0, 64'h10, 64'h0, 2'd0, 1, 64'h1122334455667788, 0, "ld_d10b");

    // Backpressure: response held while the next request waits.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 64'h10; resp_ready = 1'b0;
    tick;
    req_size = 2'd0; req_addr = 64'h14;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("bp.resp_valid", 64'(resp_valid), 64'd1);
      chk("bp.resp_rdata", resp_rdata, 64'h1122334455667788);
      chk("bp.req_ready", 64'(req_ready), 64'd0);
      tick;
    end
    resp_ready = 1'b1;
    #1 chk("b2b.req_ready", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("b2b.exec_resp_valid", 64'(resp_valid), 64'd0);
    chk("b2b.exec_dataadr", mem_dataadr, 64'h14);
    chk("b2b.exec_dword", 64'(mem_dword), 64'd0);
    tick;
    chk("b2b.resp_valid", 64'(resp_valid), 64'd1);
    chk("b2b.resp_rdata", resp_rdata, 64'h55);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;

    // Reset during EXEC of a dword store aborts the write.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 64'h20;
    req_wdata = 64'hCAFEF00DCAFEF00D;
    tick;
    req_valid = 1'b0;
    chk("rx.exec_memwrite", 64'(mem_memwrite), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rx.memwrite_async", 64'(mem_memwrite), 64'd0);
    chk("rx.resp_valid", 64'(resp_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("rx.req_ready", 64'(req_ready), 64'd1);
    chk("rx.resp_valid_rel", 64'(resp_valid), 64'd0);
    tick;
    xact(0, 2, 0, 64'h20, 64'h0, 2'd0, 1, 64'h0, 0, "rx_ld20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit sitting directly upstream of the unified 64-bit instruction/data memory (`mem`) in the MIPS datapath. It accepts one load or store request at a time from the pipeline over a valid/ready handshake. It translates each request into the memory's `dword`/`memwrite`/`dataadr`/`writedata` controls and extracts and extends load data from `readdata`. It also flags misaligned or illegal accesses instead of issuing them.

Parameters:
N, 64, data/address width; must match the memory's N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  LSU can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = word (32b), 2 = dword (64b), 3 = illegal.
- req_signed  in  1  sign-extend load result (byte/word only).
- req_addr  in  N  byte address.
- req_wdata  in  N  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline consumes response.
- resp_rdata  out  N  load result; 0 for stores and errors.
- resp_err  out  1  access was misaligned or illegal; no memory effect.
- mem_dword  out  1  to `mem.dword`.
- mem_memwrite  out  2  to `mem.memwrite`: 0 none, 1 word, 2 byte, 3 dword.
- mem_dataadr  out  N  to `mem.dataadr`.
- mem_writedata  out  N  to `mem.writedata`.
- mem_readdata  in  N  from `mem.readdata`; combinational read.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; all request and response registers cleared.
  - req_ready = 1 once reset is released; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_memwrite = 0, mem_dword = 0, mem_dataadr = 0, mem_writedata = 0.
  - mem_memwrite is 0 immediately on rst_n falling, including mid-EXEC; the store is aborted.
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state == IDLE) | (state == RESP & resp_ready).
- A request is accepted when req_valid & req_ready. On acceptance, write/size/signed/addr/wdata are registered and the FSM moves to EXEC.
- Alignment check, applied at acceptance:
  - word requires addr[1:0] == 0.
  - dword requires addr[2:0] == 0.
  - byte is always aligned.
  - size 3 is illegal.
  - A failing request sets an internal err flag.
- EXEC lasts exactly one cycle:
  - mem_dataadr = registered addr.
  - Store, no error: mem_writedata = registered wdata; mem_memwrite = 2 / 1 / 3 for byte / word / dword, asserted for this cycle only.
  - Load: mem_dword = 1 for dword, else 0; mem_memwrite = 0.
  - Error: mem_memwrite = 0, mem_dword = 0.
  - At the end of the cycle the FSM captures resp_rdata and resp_err and moves to RESP.
- Load data extraction (big-endian, as stored by the memory); w = mem_readdata[31:0]:
  - dword: mem_readdata.
  - word: w, zero- or sign-extended from bit 31.
  - byte: lane by addr[1:0]; 00 → w[31:24], 01 → w[23:16], 10 → w[15:8], 11 → w[7:0]. Zero- or sign-extended from bit 7.
  - req_signed is ignored for dword.
- RESP: resp_valid = 1 and held stable until resp_ready.
  - resp_ready with no new request → IDLE.
  - resp_ready with req_valid → back-to-back accept; next state EXEC.
- Latency: acceptance in cycle 0 → memory access in cycle 1 → resp_valid in cycle 2. Peak throughput is 1 request per 2 cycles.
- Outside EXEC: mem_memwrite = 0, mem_dword = 0; mem_dataadr and mem_writedata hold their last values.

Test Plan:
- Reset: assert rst_n = 0 during EXEC of a dword store → mem_memwrite drops to 0 immediately; after release, req_ready = 1, resp_valid = 0, and the memory word is unchanged.
- Dword store then load: store addr 0x10, data 0x1122334455667788 → one cycle with mem_memwrite = 3. Load dword from 0x10 → resp_rdata = 0x1122334455667788, resp_err = 0, resp_valid in cycle 2.
- Byte loads from the same dword:
  - unsigned, addr 0x14 → 0x55.
  - signed, addr 0x17 → 0x...88 sign-extended = 0xFFFFFFFFFFFFFF88.
  - signed, addr 0x11 → 0x22.
- Word store/load: store word 0x80000001 at 0x1C, then load word signed → 0xFFFFFFFF80000001; load unsigned → 0x0000000080000001.
- Misaligned/illegal accesses: word store at 0x1A, dword load at 0x14, and size = 3 → mem_memwrite stays 0 throughout; resp_err = 1; resp_rdata = 0; memory contents unchanged.
- Back-to-back with backpressure: hold resp_ready = 0 for 3 cycles → resp_valid and resp_rdata stay stable and req_ready = 0. Then assert resp_ready with req_valid = 1 → the new request is accepted in the same cycle and EXEC follows immediately.
